btn_pulse_gen: RTL and testbench

- Parametrised multi-channel push-button front end. Runs on the 200 Hz scan clock.
- Per channel: synchronises a raw button input, debounces it, and emits single-cycle pulses on selected edges.
- Optional auto-repeat emits extra press pulses while a button is held.
- Feeds counter/display control logic that needs exactly one pulse per user action.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_channel.sv | 110 +++++++++++
 rtl/btn_pulse_gen.sv | 46 ++++
 tb/tb_btn_pulse_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and helpers for the push-button pulse generator
package btn_pkg;

   // Edge selection codes for EDGE_MODE
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   // Default timing for a 200 Hz scan clock
   localparam int DEF_NCH        = 4;
   localparam int DEF_STABLE_CNT = 4;    // 20 ms debounce
   localparam int DEF_HOLD_CNT   = 100;  // 0.5 s before first repeat
   localparam int DEF_REPEAT_CNT = 20;   // 0.1 s between repeats

   // Number of bits needed to hold values 0 .. value-1
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debouncer, edge qualifier, auto-repeat
module btn_channel
   import btn_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int EDGE_MODE  = EDGE_RISE,
   parameter int HOLD_CNT   = DEF_HOLD_CNT,
   parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
   input  logic clk_200h,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic level,
   output logic pulse
);

   localparam int DB_W = clog2(STABLE_CNT + 1);
   localparam int RP_W = clog2(max2(HOLD_CNT, REPEAT_CNT) + 1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(STABLE_CNT - 1);
   localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CNT - 1);
   localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CNT - 1);

   logic            r_s1;
   logic            r_s2;
   logic            r_level;
   logic [DB_W-1:0] r_db_cnt;
   logic [RP_W-1:0] r_rp_cnt;
   logic            r_first;
   logic            r_pulse;

   logic w_differs;
   logic w_flip;
   logic w_rise;
   logic w_fall;
   logic w_edge_hit;
   logic w_rp_active;
   logic w_rp_fire;

   assign w_differs   = (r_s2 != r_level);
   assign w_flip      = w_differs && (r_db_cnt == DB_LAST);
   assign w_rise      = w_flip && r_s2;
   assign w_fall      = w_flip && !r_s2;
   assign w_rp_active = r_level && repeat_en;
   assign w_rp_fire   = w_rp_active &&
                        (r_first ? (r_rp_cnt == HOLD_LAST) : (r_rp_cnt == REP_LAST));

   // Pick which debounced transitions count as events
   always_comb begin
      w_edge_hit = 1'b0;
      case (EDGE_MODE)
         EDGE_FALL: w_edge_hit = w_fall;
         EDGE_BOTH: w_edge_hit = w_rise | w_fall;
         default:   w_edge_hit = w_rise;
      endcase
   end

   // Two-flop synchroniser for the asynchronous button level
   always_ff @(posedge clk_200h) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= btn_in;
         r_s2 <= r_s1;
      end
   end

   // Debounce: level follows s2 only after STABLE_CNT consecutive differing samples
   always_ff @(posedge clk_200h) begin
      if (rst) begin
         r_level  <= 1'b0;
         r_db_cnt <= '0;
      end else if (!w_differs) begin
         r_db_cnt <= '0;
      end else if (w_flip) begin
         r_level  <= r_s2;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   // Auto-repeat timer: HOLD_CNT to the first repeat, then every REPEAT_CNT
   always_ff @(posedge clk_200h) begin
      if (rst) begin
         r_rp_cnt <= '0;
         r_first  <= 1'b1;
      end else if (!w_rp_active) begin
         r_rp_cnt <= '0;
         r_first  <= 1'b1;
      end else if (w_rp_fire) begin
         r_rp_cnt <= '0;
         r_first  <= 1'b0;
      end else begin
         r_rp_cnt <= r_rp_cnt + 1'b1;
      end
   end

   // Edge and repeat events merge into a single registered pulse
   always_ff @(posedge clk_200h) begin
      if (rst) r_pulse <= 1'b0;
      else     r_pulse <= w_edge_hit | w_rp_fire;
   end

   assign level = r_level;
   assign pulse = r_pulse;

endmodule

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - multi-channel push-button pulse generator top
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int NCH        = DEF_NCH,
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int EDGE_MODE  = EDGE_RISE,
   parameter int HOLD_CNT   = DEF_HOLD_CNT,
   parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
   input  logic           clk_200h,
   input  logic           rst,
   input  logic [NCH-1:0] btn_in,
   input  logic           repeat_en,
   output logic [NCH-1:0] level,
   output logic [NCH-1:0] pulse,
   output logic           any_pulse
);

   logic r_any_pulse;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      btn_channel #(
         .STABLE_CNT (STABLE_CNT),
         .EDGE_MODE  (EDGE_MODE),
         .HOLD_CNT   (HOLD_CNT),
         .REPEAT_CNT (REPEAT_CNT)
      ) u_ch (
         .clk_200h  (clk_200h),
         .rst       (rst),
         .btn_in    (btn_in[g]),
         .repeat_en (repeat_en),
         .level     (level[g]),
         .pulse     (pulse[g])
      );
   end

   // Summary event flag, one cycle behind the per-channel pulses
   always_ff @(posedge clk_200h) begin
      if (rst) r_any_pulse <= 1'b0;
      else     r_any_pulse <= |pulse;
   end

   assign any_pulse = r_any_pulse;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - scoreboard bench for btn_pulse_gen in rise, fall and both modes
module tb_btn_pulse_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic       ren;
   logic [3:0] lvl_o [3];
   logic [3:0] pul_o [3];
   logic [2:0] any_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   int         exp_t [3][$];
   logic [3:0] exp_m [3][$];
   int         exp_a [3][$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   btn_pulse_gen #(.NCH(4), .STABLE_CNT(4), .EDGE_MODE(0), .HOLD_CNT(100), .REPEAT_CNT(20)) dut_rise (
      .clk_200h(clk), .rst(rst), .btn_in(btn), .repeat_en(ren),
      .level(lvl_o[0]), .pulse(pul_o[0]), .any_pulse(any_o[0]));

   btn_pulse_gen #(.NCH(4), .STABLE_CNT(4), .EDGE_MODE(1), .HOLD_CNT(100), .REPEAT_CNT(20)) dut_fall (
      .clk_200h(clk), .rst(rst), .btn_in(btn), .repeat_en(ren),
      .level(lvl_o[1]), .pulse(pul_o[1]), .any_pulse(any_o[1]));

   btn_pulse_gen #(.NCH(4), .STABLE_CNT(4), .EDGE_MODE(2), .HOLD_CNT(100), .REPEAT_CNT(20)) dut_both (
      .clk_200h(clk), .rst(rst), .btn_in(btn), .repeat_en(ren),
      .level(lvl_o[2]), .pulse(pul_o[2]), .any_pulse(any_o[2]));

   task automatic expect_ev(input int d, input int t, input logic [3:0] m);
      exp_t[d].push_back(t);
      exp_m[d].push_back(m);
      exp_a[d].push_back(t + 1);
   endtask

   task automatic rise_ev(input int t, input logic [3:0] m);
      expect_ev(0, t, m);
      expect_ev(2, t, m);
   endtask

   task automatic fall_ev(input int t, input logic [3:0] m);
      expect_ev(1, t, m);
      expect_ev(2, t, m);
   endtask

   task automatic rep_ev(input int t, input logic [3:0] m);
      expect_ev(0, t, m);
      expect_ev(1, t, m);
      expect_ev(2, t, m);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      int         te;
      logic [3:0] me;
      if (mon_en) begin
         for (int d = 0; d < 3; d++) begin
            if (pul_o[d] != 4'd0) begin
               checks++;
               if (exp_t[d].size() == 0) begin
                  errors++;
                  $display("FAIL pulse dut%0d: unexpected mask %h at cyc %0d", d, pul_o[d], cyc);
               end else begin
                  te = exp_t[d].pop_front();
                  me = exp_m[d].pop_front();
                  if (te != cyc || me != pul_o[d]) begin
                     errors++;
                     $display("FAIL pulse dut%0d: got mask %h at cyc %0d expected mask %h at cyc %0d",
                              d, pul_o[d], cyc, me, te);
                  end
               end
            end
            if (any_o[d]) begin
               checks++;
               if (exp_a[d].size() == 0) begin
                  errors++;
                  $display("FAIL any_pulse dut%0d: unexpected at cyc %0d", d, cyc);
               end else begin
                  te = exp_a[d].pop_front();
                  if (te != cyc) begin
                     errors++;
                     $display("FAIL any_pulse dut%0d: got cyc %0d expected cyc %0d", d, cyc, te);
                  end
               end
            end
         end
      end
   end

   initial begin
      int c;
      int r;
      bit bp [5];
      bp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      btn = 4'd0;
      ren = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset level dut%0d", d), lvl_o[d], 0);
         chk($sformatf("reset pulse dut%0d", d), pul_o[d], 0);
         chk($sformatf("reset any dut%0d", d), any_o[d], 0);
      end

      // clean press / release on channel 0
      wait_to(10);
      c = cyc;
      btn[0] = 1'b1;
      rise_ev(c + 6, 4'h1);
      fall_ev(c + 16, 4'h1);
      wait_to(c + 5);
      chk("t1 level before debounce", lvl_o[0], 0);
      wait_to(c + 6);
      chk("t1 level after debounce", lvl_o[0], 1);
      wait_to(c + 10);
      btn[0] = 1'b0;
      wait_to(c + 15);
      chk("t1 level still held", lvl_o[0], 1);
      wait_to(c + 16);
      chk("t1 level released", lvl_o[0], 0);
      wait_to(c + 30);

      // bounce on channel 1: 1,1,1,0 then held high
      c = cyc;
      for (int i = 0; i < 5; i++) begin
         wait_to(c + i);
         btn[1] = bp[i];
      end
      rise_ev(c + 10, 4'h2);
      wait_to(c + 9);
      chk("t2 glitch rejected", lvl_o[0], 0);
      wait_to(c + 10);
      chk("t2 level after bounce", lvl_o[0], 2);
      wait_to(c + 20);
      btn[1] = 1'b0;
      fall_ev(c + 26, 4'h2);
      wait_to(c + 40);

      // auto-repeat on channel 2
      c = cyc;
      ren    = 1'b1;
      btn[2] = 1'b1;
      r = c + 6;
      rise_ev(r, 4'h4);
      for (int k = 1; k <= 5; k++) rep_ev(r + 80 + 20 * k, 4'h4);
      fall_ev(r + 196, 4'h4);
      wait_to(r + 190);
      btn[2] = 1'b0;
      wait_to(r + 210);

      // repeat_en dropped after the first repeat
      c = cyc;
      btn[2] = 1'b1;
      r = c + 6;
      rise_ev(r, 4'h4);
      rep_ev(r + 100, 4'h4);
      fall_ev(r + 146, 4'h4);
      wait_to(r + 109);
      ren = 1'b0;
      wait_to(r + 140);
      btn[2] = 1'b0;
      wait_to(r + 160);

      // reset while held with the repeat timer running
      c = cyc;
      ren    = 1'b1;
      btn[2] = 1'b1;
      r = c + 6;
      rise_ev(r, 4'h4);
      wait_to(r + 50);
      chk("t5 level before reset", lvl_o[0], 4);
      rst = 1'b1;
      wait_to(r + 51);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("t5 level cleared dut%0d", d), lvl_o[d], 0);
         chk($sformatf("t5 pulse cleared dut%0d", d), pul_o[d], 0);
         chk($sformatf("t5 any cleared dut%0d", d), any_o[d], 0);
      end
      rise_ev(r + 57, 4'h4);
      rep_ev(r + 157, 4'h4);
      fall_ev(r + 166, 4'h4);
      wait_to(r + 160);
      btn[2] = 1'b0;
      ren    = 1'b0;
      wait_to(r + 180);

      // independent channels, staggered presses, simultaneous release
      c = cyc;
      for (int i = 0; i < 4; i++) begin
         wait_to(c + i);
         btn[i] = 1'b1;
         rise_ev(c + i + 6, 4'(1 << i));
      end
      wait_to(c + 20);
      btn = 4'd0;
      fall_ev(c + 26, 4'hF);
      wait_to(c + 40);

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("missing pulses dut%0d", d), exp_t[d].size(), 0);
         chk($sformatf("missing any dut%0d", d), exp_a[d].size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
